// File: rtl/axi_ar_decerr_responder.sv
// axi_ar_decerr_responder
//   Answers an AR request that the address decoder could not route. It waits
//   for the port's legal reads to drain, returns ARLEN+1 DECERR beats on R,
//   then pulses error_gnt_o so the decoder can leave its ERROR state.
//   Optional error log (address of last fault, saturating fault count) is
//   built only when AR_ERR_LOG_EN is defined.
module axi_ar_decerr_responder #(
  parameter int          ID_WIDTH    = 4,
  parameter int          USER_WIDTH  = 6,
  parameter int          DATA_WIDTH  = 64,
  parameter logic [31:0] ERR_PATTERN = 32'hBADC_AB1E
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_ardata_info_i,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [7:0]            arlen_i,
  input  logic [USER_WIDTH-1:0] aruser_i,
  input  logic [31:0]           araddr_i,
  input  logic                  outstanding_trans_i,
  output logic                  error_gnt_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [ID_WIDTH-1:0]   rid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic [USER_WIDTH-1:0] ruser_o,
  output logic                  busy_o
`ifdef AR_ERR_LOG_EN
  ,
  input  logic                  err_clr_i,
  output logic [31:0]           err_addr_o,
  output logic [15:0]           err_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, DRAIN, RESP, GRANT} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [USER_WIDTH-1:0] ruser_q, ruser_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic                  gnt_q, gnt_d;
  logic                  capture;

  // A capture is only honoured while idle; a pulse in any other state is dropped.
  assign capture = (state_q == IDLE) && sample_ardata_info_i;

  // Next-state and registered-output logic for the response FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rid_d    = rid_q;
    ruser_d  = ruser_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    gnt_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_ardata_info_i) begin
          rid_d   = arid_i;
          ruser_d = aruser_i;
          cnt_d   = arlen_i;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!outstanding_trans_i) begin
          rvalid_d = 1'b1;
          rlast_d  = (cnt_q == 8'd0);
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rvalid_q && rready_i) begin
          if (cnt_q != 8'd0) begin
            cnt_d   = cnt_q - 8'd1;
            rlast_d = (cnt_q == 8'd1);
          end else begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            gnt_d    = 1'b1;
            state_d  = GRANT;
          end
        end
      end
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output flops; reset aborts any burst without granting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rid_q    <= '0;
      ruser_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      gnt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rid_q    <= rid_d;
      ruser_q  <= ruser_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      gnt_q    <= gnt_d;
    end
  end

  assign error_gnt_o = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign rlast_o     = rlast_q;
  assign rid_o       = rid_q;
  assign ruser_o     = ruser_q;
  assign rdata_o     = {(DATA_WIDTH/32){ERR_PATTERN}};
  assign rresp_o     = 2'b11;
  assign busy_o      = (state_q != IDLE);

`ifdef AR_ERR_LOG_EN
  logic [31:0] err_addr_q;
  logic [15:0] err_cnt_q;

  // Fault log: clear has priority over a same-cycle capture; count saturates.
  always_ff @(posedge clk) begin
    if (rst || err_clr_i) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else if (capture) begin
      err_addr_q <= araddr_i;
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;
`else
  logic unused_log;
  assign unused_log = ^{araddr_i, capture};
`endif

  // The decoder must stay stalled in ERROR until granted, so a new sample
  // while busy points at a decoder bug; the block itself just ignores it.
  a_no_sample_when_busy: assert property (@(posedge clk) disable iff (rst)
    !(sample_ardata_info_i && (state_q != IDLE)))
    else $warning("illegal sample_ardata_info_i while responder busy");

endmodule

// File: tb/tb_axi_ar_decerr_responder.sv
// Bench for axi_ar_decerr_responder: table of bursts plus hand-written
// latency / reset / illegal-sample sequences; beats checked via a queue.
module tb_axi_ar_decerr_responder;
  localparam int          IDW = 4;
  localparam int          UW  = 6;
  localparam int          DW  = 64;
  localparam logic [63:0] EXP_DATA = {2{32'hBADC_AB1E}};

  logic           clk = 1'b0;
  logic           rst;
  logic           sample;
  logic [IDW-1:0] arid;
  logic [7:0]     arlen;
  logic [UW-1:0]  aruser;
  logic [31:0]    araddr;
  logic           outstanding;
  logic           gnt;
  logic           rvalid;
  logic           rready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic [UW-1:0]  ruser;
  logic           busy;
`ifdef AR_ERR_LOG_EN
  logic           err_clr;
  logic [31:0]    err_addr;
  logic [15:0]    err_cnt;
`endif

  axi_ar_decerr_responder dut (
    .clk(clk), .rst(rst),
    .sample_ardata_info_i(sample), .arid_i(arid), .arlen_i(arlen),
    .aruser_i(aruser), .araddr_i(araddr), .outstanding_trans_i(outstanding),
    .error_gnt_o(gnt), .rvalid_o(rvalid), .rready_i(rready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
    .ruser_o(ruser), .busy_o(busy)
`ifdef AR_ERR_LOG_EN
    , .err_clr_i(err_clr), .err_addr_o(err_addr), .err_cnt_o(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [UW-1:0]  user;
    logic           last;
  } beat_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     len;
    logic [UW-1:0]  user;
    int             wait_c;
    bit             toggle;
    logic [31:0]    addr;
  } vec_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    gnt_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop/compare every transferred beat, check stall stability, count grants.
  initial begin : monitor
    logic           prev_stall;
    logic [IDW-1:0] p_id;
    logic [UW-1:0]  p_user;
    logic           p_last;
    beat_t          b;
    prev_stall = 1'b0;
    p_id = '0; p_user = '0; p_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_rvalid", {63'd0, rvalid}, 64'd1);
          chk("stall_rid", {60'd0, rid}, {60'd0, p_id});
          chk("stall_ruser", {58'd0, ruser}, {58'd0, p_user});
          chk("stall_rlast", {63'd0, rlast}, {63'd0, p_last});
        end
        if (rvalid && rready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
          end else begin
            b = exp_q.pop_front();
            chk("beat_rid", {60'd0, rid}, {60'd0, b.id});
            chk("beat_ruser", {58'd0, ruser}, {58'd0, b.user});
            chk("beat_rlast", {63'd0, rlast}, {63'd0, b.last});
            chk("beat_rdata", rdata, EXP_DATA);
            chk("beat_rresp", {62'd0, rresp}, 64'd3);
          end
        end
        if (gnt) gnt_cnt++;
        prev_stall = rvalid && !rready;
        p_id = rid; p_user = ruser; p_last = rlast;
      end
    end
  end

  task automatic push_beats(input vec_t v);
    for (int i = 0; i <= int'(v.len); i++)
      exp_q.push_back('{id: v.id, user: v.user, last: (i == int'(v.len))});
  endtask

  task automatic wait_grant(input int g0, input bit toggle);
    for (int i = 0; i < 3000; i++) begin
      if (gnt_cnt != g0) break;
      if (toggle) rready = ~rready;
      tick();
    end
    chk("gnt_once", gnt_cnt - g0, 64'd1);
    chk("queue_drained", exp_q.size(), 64'd0);
    chk("busy_after_gnt", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_burst(input vec_t v);
    int g0;
    int bad;
    g0 = gnt_cnt;
    bad = 0;
    push_beats(v);
    sample = 1'b1; arid = v.id; arlen = v.len; aruser = v.user; araddr = v.addr;
    outstanding = (v.wait_c > 0);
    rready = !v.toggle;
    tick();
    sample = 1'b0;
    for (int i = 0; i < v.wait_c; i++) begin
      @(negedge clk);
      if (rvalid) bad++;
      tick();
    end
    if (v.wait_c > 0) chk("drain_no_rvalid", bad, 64'd0);
    outstanding = 1'b0;
    wait_grant(g0, v.toggle);
  endtask

  vec_t vecs[4];

  initial begin : stim
    int g0;
    vecs[0] = '{id: 4'h4, len: 8'd3,   user: 6'h2A, wait_c: 5, toggle: 1'b0, addr: 32'h0};
    vecs[1] = '{id: 4'hF, len: 8'd255, user: 6'h3F, wait_c: 0, toggle: 1'b1, addr: 32'h0};
    vecs[2] = '{id: 4'h1, len: 8'd1,   user: 6'h01, wait_c: 2, toggle: 1'b1, addr: 32'h0};
    vecs[3] = '{id: 4'h7, len: 8'd7,   user: 6'h11, wait_c: 0, toggle: 1'b0, addr: 32'h0};

    rst = 1'b1; sample = 1'b0; arid = '0; arlen = '0; aruser = '0; araddr = '0;
    outstanding = 1'b0; rready = 1'b0;
`ifdef AR_ERR_LOG_EN
    err_clr = 1'b0;
`endif
    repeat (3) tick();
    @(negedge clk);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_rlast", {63'd0, rlast}, 64'd0);
    chk("rst_gnt", {63'd0, gnt}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rid", {60'd0, rid}, 64'd0);
    chk("rst_ruser", {58'd0, ruser}, 64'd0);
    rst = 1'b0;
    tick();

    // Single beat, exact latency of rvalid and grant.
    g0 = gnt_cnt;
    exp_q.push_back('{id: 4'd3, user: 6'h05, last: 1'b1});
    sample = 1'b1; arid = 4'd3; arlen = 8'd0; aruser = 6'h05; rready = 1'b1; outstanding = 1'b0;
    tick();
    sample = 1'b0;
    @(negedge clk);
    chk("t1_no_rvalid_c1", {63'd0, rvalid}, 64'd0);
    tick();
    @(negedge clk);
    chk("t1_rvalid_c2", {63'd0, rvalid}, 64'd1);
    chk("t1_rlast", {63'd0, rlast}, 64'd1);
    chk("t1_rid", {60'd0, rid}, 64'd3);
    chk("t1_rresp", {62'd0, rresp}, 64'd3);
    tick();
    @(negedge clk);
    chk("t1_gnt", {63'd0, gnt}, 64'd1);
    chk("t1_rvalid_off", {63'd0, rvalid}, 64'd0);
    tick();
    @(negedge clk);
    chk("t1_gnt_off", {63'd0, gnt}, 64'd0);
    chk("t1_busy_off", {63'd0, busy}, 64'd0);
    chk("t1_gnt_count", gnt_cnt - g0, 64'd1);
    tick();

    // Table-driven bursts.
    for (int i = 0; i < 3; i++) run_burst(vecs[i]);

    // Reset during the second beat of an 8-beat burst.
    g0 = gnt_cnt;
    exp_q.push_back('{id: 4'h7, user: 6'h11, last: 1'b0});
    sample = 1'b1; arid = 4'h7; arlen = 8'd7; aruser = 6'h11; rready = 1'b1;
    tick();
    sample = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_rvalid_after_rst", {63'd0, rvalid}, 64'd0);
    chk("t4_busy_after_rst", {63'd0, busy}, 64'd0);
    chk("t4_no_gnt", gnt_cnt - g0, 64'd0);
    chk("t4_queue", exp_q.size(), 64'd0);
    tick();
    run_burst(vecs[3]);

    // Illegal second sample during RESP is ignored.
    g0 = gnt_cnt;
    push_beats('{id: 4'h6, len: 8'd3, user: 6'h06, wait_c: 0, toggle: 1'b0, addr: 32'h0});
    sample = 1'b1; arid = 4'h6; arlen = 8'd3; aruser = 6'h06; rready = 1'b0;
    tick();
    sample = 1'b0;
    tick();
    sample = 1'b1; arid = 4'h9; arlen = 8'd10; aruser = 6'h19;
    tick();
    sample = 1'b0;
    rready = 1'b1;
    wait_grant(g0, 1'b0);
    g0 = gnt_cnt;
    repeat (4) tick();
    chk("t5_no_extra_gnt", gnt_cnt - g0, 64'd0);
    chk("t5_idle", {63'd0, busy}, 64'd0);

`ifdef AR_ERR_LOG_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    for (int i = 1; i <= 3; i++)
      run_burst('{id: 4'h2, len: 8'd0, user: 6'h0, wait_c: 0, toggle: 1'b0, addr: 32'h1000 * i});
    chk("t6_err_cnt", {48'd0, err_cnt}, 64'd3);
    chk("t6_err_addr", {32'd0, err_addr}, 64'h3000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t6_clr_cnt", {48'd0, err_cnt}, 64'd0);
    chk("t6_clr_addr", {32'd0, err_addr}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
